// File: rtl/trace_issue_queue_pkg.sv
// Shared types for the trace issue queue: trace operations, queue entries and scheduler states.
package trace_issue_queue_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FETCH = 2'd3
  } parsed_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tiq_state_t;

  localparam int TIQ_ADDRESS_WIDTH = 33;
  localparam int TIQ_TIME_WIDTH    = 64;

  // Entry layout at the default widths; the queue builds the same layout from its own parameters.
  typedef struct packed {
    logic [TIQ_TIME_WIDTH-1:0]    stamp;
    parsed_op_t                   op;
    logic [TIQ_ADDRESS_WIDTH-1:0] addr;
  } trace_entry_t;

endpackage

// File: rtl/trace_issue_queue_if.sv
// Input trace stream, output request stream and status signals of the trace issue queue.
interface trace_issue_queue_if
  import trace_issue_queue_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 33,
  parameter int TIME_WIDTH    = 64,
  parameter int STAT_WIDTH    = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [TIME_WIDTH-1:0]    in_time;
  parsed_op_t               in_op;
  logic [ADDRESS_WIDTH-1:0] in_addr;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  parsed_op_t               out_op;
  logic [ADDRESS_WIDTH-1:0] out_addr;
  logic [TIME_WIDTH-1:0]    out_time;
  logic                     out_late;
  logic [TIME_WIDTH-1:0]    cycle_count;
  logic [STAT_WIDTH-1:0]    issued_count;
  logic [STAT_WIDTH-1:0]    late_count;
  logic                     err_order;
  logic                     done;

  modport slave (
    input  in_valid, in_time, in_op, in_addr, in_last, out_ready,
    output in_ready, out_valid, out_op, out_addr, out_time, out_late,
           cycle_count, issued_count, late_count, err_order, done
  );

  modport master (
    output in_valid, in_time, in_op, in_addr, in_last, out_ready,
    input  in_ready, out_valid, out_op, out_addr, out_time, out_late,
           cycle_count, issued_count, late_count, err_order, done
  );
endinterface

// File: rtl/trace_issue_queue_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_issue_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o = wrPtr_q - rdPtr_q;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push_i && !full_o)  wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (pop_i  && !empty_o) rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/trace_issue_queue.sv
// Holds time-stamped trace requests and releases each once the cycle counter reaches its timestamp.
module trace_issue_queue
  import trace_issue_queue_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 33,
  parameter int TIME_WIDTH    = 64,
  parameter int DEPTH         = 16,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  trace_issue_queue_if.slave  bus
);
  typedef struct packed {
    logic [TIME_WIDTH-1:0]    stamp;
    parsed_op_t               op;
    logic [ADDRESS_WIDTH-1:0] addr;
  } entry_t;

  entry_t                   wrEntry, headEntry;
  logic                     fifoFull, fifoEmpty;
  logic [$clog2(DEPTH):0]   fifoCount;
  logic                     push, pop, headEligible, headLate;

  logic [TIME_WIDTH-1:0]    cycle_q, cycle_d;
  logic [TIME_WIDTH-1:0]    lastTime_q, lastTime_d;
  logic [STAT_WIDTH-1:0]    issued_q, issued_d;
  logic [STAT_WIDTH-1:0]    late_q, late_d;
  logic                     errOrder_q, errOrder_d;
  logic                     lastSeen_q, lastSeen_d;
  tiq_state_t               state_q, state_d;

  assign wrEntry = '{stamp: bus.in_time, op: bus.in_op, addr: bus.in_addr};

  trace_issue_queue_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wrEntry),
    .rdata_o (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // in_ready ignores pops, so a full queue never accepts in the cycle it drains one entry.
  assign bus.in_ready  = !rst && !fifoFull;
  assign push          = bus.in_valid && bus.in_ready;
  assign headEligible  = !fifoEmpty && (cycle_q >= headEntry.stamp);
  assign headLate      = headEligible && (cycle_q > headEntry.stamp);
  assign pop           = headEligible && bus.out_ready;

  assign bus.out_valid    = headEligible;
  assign bus.out_late     = headLate;
  assign bus.out_op       = fifoEmpty ? NOP : headEntry.op;
  assign bus.out_addr     = fifoEmpty ? '0  : headEntry.addr;
  assign bus.out_time     = fifoEmpty ? '0  : headEntry.stamp;
  assign bus.cycle_count  = cycle_q;
  assign bus.issued_count = issued_q;
  assign bus.late_count   = late_q;
  assign bus.err_order    = errOrder_q;

  always_comb begin
    cycle_d    = cycle_q;
    issued_d   = issued_q;
    late_d     = late_q;
    lastTime_d = lastTime_q;
    errOrder_d = errOrder_q;
    lastSeen_d = lastSeen_q;
    if (cycle_q != '1) cycle_d = cycle_q + TIME_WIDTH'(1);
    if (pop && issued_q != '1) issued_d = issued_q + STAT_WIDTH'(1);
    if (pop && headLate && late_q != '1) late_d = late_q + STAT_WIDTH'(1);
    if (push) begin
      lastTime_d = bus.in_time;
      if (bus.in_time < lastTime_q) errOrder_d = 1'b1;
      if (bus.in_last) lastSeen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q    <= '0;
      issued_q   <= '0;
      late_q     <= '0;
      lastTime_q <= '0;
      errOrder_q <= 1'b0;
      lastSeen_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      issued_q   <= issued_d;
      late_q     <= late_d;
      lastTime_q <= lastTime_d;
      errOrder_q <= errOrder_d;
      lastSeen_q <= lastSeen_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = bus.in_last ? DRAIN : RUN;
      RUN:     if (push && bus.in_last) state_d = DRAIN;
      DRAIN:   if (fifoCount == '0 && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.done = lastSeen_q && fifoEmpty;
  end

endmodule

// File: tb/tb_trace_issue_queue.sv
// Randomised scoreboard bench for trace_issue_queue with a queue-based reference of the schedule.
module tb_trace_issue_queue;
  import trace_issue_queue_pkg::*;

  localparam int AWID  = 33;
  localparam int TWID  = 64;
  localparam int SWID  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [TWID-1:0] stamp;
    parsed_op_t      op;
    logic [AWID-1:0] addr;
  } expEntry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_issue_queue_if #(.ADDRESS_WIDTH(AWID), .TIME_WIDTH(TWID), .STAT_WIDTH(SWID)) bus ();

  trace_issue_queue #(
    .ADDRESS_WIDTH (AWID),
    .TIME_WIDTH    (TWID),
    .DEPTH         (DEPTH),
    .STAT_WIDTH    (SWID)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  expEntry_t       sbQueue[$];
  int              testsRun    = 0;
  int              testsFailed = 0;
  logic [TWID-1:0] expCycle    = '0;
  logic [TWID-1:0] lastAccTime = '0;
  int              expIssued   = 0;
  int              expLate     = 0;
  bit              expErr      = 0;
  bit              expLastSeen = 0;

  task automatic checkOutput(input string name, input logic [TWID-1:0] actual,
                             input logic [TWID-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic noteTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got timeout, expected completion at %0t", name, $time);
  endtask

  // Drive one entry until accepted; the expected response enters the scoreboard at the accepting edge.
  task automatic applyStimulus(input logic [TWID-1:0] stamp, input parsed_op_t op,
                               input logic [AWID-1:0] addr, input bit last);
    bit accepted = 0;
    expEntry_t e;
    bus.in_valid = 1'b1;
    bus.in_time  = stamp;
    bus.in_op    = op;
    bus.in_addr  = addr;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1;
    end
    if (!accepted) begin
      noteTimeout("accept");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.stamp = stamp;
    e.op    = op;
    e.addr  = addr;
    sbQueue.push_back(e);
    if (stamp < lastAccTime) expErr = 1;
    lastAccTime = stamp;
    if (last) expLastSeen = 1;
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    sbQueue.delete();
    expCycle    = '0;
    lastAccTime = '0;
    expIssued   = 0;
    expLate     = 0;
    expErr      = 0;
    expLastSeen = 0;
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_late", bus.out_late, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err_order", bus.err_order, 0);
    checkOutput("rst_cycle", bus.cycle_count, 0);
    checkOutput("rst_issued", bus.issued_count, 0);
    checkOutput("rst_late", bus.late_count, 0);
    checkOutput("rst_out_op", bus.out_op, NOP);
    checkOutput("rst_out_addr", bus.out_addr, 0);
    checkOutput("rst_out_time", bus.out_time, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sbQueue.size() != 0; i++) @(negedge clk);
    if (sbQueue.size() != 0) noteTimeout("drain");
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every visible output against the reference, then retires the head on a handshake.
  always @(negedge clk) begin : monitor
    bit expValid;
    bit expLateNow;
    if (!rst) begin
      expValid   = (sbQueue.size() > 0) && (expCycle >= sbQueue[0].stamp);
      expLateNow = expValid && (expCycle > sbQueue[0].stamp);
      checkOutput("cycle_count", bus.cycle_count, expCycle);
      checkOutput("out_valid", bus.out_valid, expValid);
      checkOutput("out_late", bus.out_late, expLateNow);
      checkOutput("in_ready", bus.in_ready, sbQueue.size() < DEPTH);
      checkOutput("err_order", bus.err_order, expErr);
      checkOutput("done", bus.done, expLastSeen && sbQueue.size() == 0);
      checkOutput("issued_count", bus.issued_count, expIssued);
      checkOutput("late_count", bus.late_count, expLate);
      if (expValid) begin
        checkOutput("out_time", bus.out_time, sbQueue[0].stamp);
        checkOutput("out_addr", bus.out_addr, sbQueue[0].addr);
        checkOutput("out_op", bus.out_op, sbQueue[0].op);
      end
      if (bus.out_valid && bus.out_ready && sbQueue.size() > 0) begin
        expIssued++;
        if (expCycle > sbQueue[0].stamp) expLate++;
        void'(sbQueue.pop_front());
      end
      expCycle = expCycle + 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit              wrapDone;
    logic [TWID-1:0] t;
    bus.in_valid  = 1'b0;
    bus.in_time   = '0;
    bus.in_op     = NOP;
    bus.in_addr   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Scheduled issue: eligible at counts 5, 10, 11; only the third is late.
    doReset();
    bus.out_ready = 1'b1;
    applyStimulus(64'd5, READ, 33'h1_0000_0005, 0);
    applyStimulus(64'd10, WRITE, 33'h0_0000_000a, 0);
    applyStimulus(64'd10, FETCH, 33'h0_1234_5678, 0);
    waitDrain(100);
    checkOutput("sched_issued", bus.issued_count, 3);
    checkOutput("sched_late", bus.late_count, 1);

    // Full queue with backpressure, then release.
    doReset();
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(64'd0, parsed_op_t'($urandom_range(0, 3)), AWID'(i + 100), 0);
      end
      begin
        repeat (12) @(negedge clk);
        checkOutput("bp_in_ready_full", bus.in_ready, 0);
        checkOutput("bp_none_issued", bus.issued_count, 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    waitDrain(100);
    checkOutput("bp_issued", bus.issued_count, 5);

    // Non-monotonic timestamps.
    doReset();
    bus.out_ready = 1'b1;
    applyStimulus(64'd20, READ, 33'h20, 0);
    applyStimulus(64'd8, WRITE, 33'h8, 0);
    checkOutput("order_err", bus.err_order, 1);
    waitDrain(100);
    checkOutput("order_late", bus.late_count, 1);

    // End of trace, then an entry after the last one.
    doReset();
    bus.out_ready = 1'b1;
    applyStimulus(64'd2, READ, 33'h2, 0);
    applyStimulus(64'd3, READ, 33'h3, 0);
    applyStimulus(64'd4, WRITE, 33'h4, 1);
    waitDrain(100);
    checkOutput("eot_done", bus.done, 1);
    repeat (5) @(posedge clk);
    #1 checkOutput("eot_done_held", bus.done, 1);
    applyStimulus(64'd0, FETCH, 33'h55, 0);
    waitDrain(100);
    checkOutput("eot_post_issued", bus.issued_count, 4);

    // Reset while entries are waiting.
    doReset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(64'd100, READ, AWID'(i), 0);
    for (int i = 0; i < 200 && bus.cycle_count < 50; i++) @(negedge clk);
    checkOutput("mid_cycle_50", bus.cycle_count, 50);
    #2;
    doReset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_restart_cycle", bus.cycle_count, 0);
    repeat (120) @(posedge clk);
    #1 checkOutput("mid_nothing_issued", bus.issued_count, 0);

    // Pointer wrap with random backpressure.
    doReset();
    wrapDone = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          applyStimulus(64'd0, parsed_op_t'($urandom_range(0, 3)), {$urandom, 1'b1}, 0);
        wrapDone = 1;
      end
      begin
        while (!wrapDone) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    waitDrain(300);
    checkOutput("wrap_issued", bus.issued_count, 40);

    // Random future and occasional past timestamps under random backpressure.
    doReset();
    wrapDone = 0;
    t = 64'd10;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 7) == 0) t = (t > 6) ? t - 6 : '0;
          else t = t + TWID'($urandom_range(0, 3));
          applyStimulus(t, parsed_op_t'($urandom_range(0, 3)), {$urandom, 1'b0}, i == 29);
        end
        wrapDone = 1;
      end
      begin
        while (!wrapDone) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    waitDrain(400);
    checkOutput("rand_issued", bus.issued_count, 30);
    checkOutput("rand_done", bus.done, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
